// File: rtl/wb_master_queue.sv
// Wishbone classic master fed by a request FIFO: one bus cycle in flight at a time,
// one response pulse per command, with bus-error and timeout reporting.
module wb_master_queue #(
  parameter int DATA_SZ_P    = 32,
  parameter int ADDR_SZ_P    = 10,
  parameter int FIFO_DEPTH_P = 4,
  parameter int TIMEOUT_P    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_cmd,
  input  logic [ADDR_SZ_P-1:0]          req_addr,
  input  logic [DATA_SZ_P-1:0]          req_data,
  output logic                          rsp_valid,
  output logic [DATA_SZ_P-1:0]          rsp_data,
  output logic                          rsp_err,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [ADDR_SZ_P-1:0]          wb_adr_o,
  output logic [DATA_SZ_P-1:0]          wb_dat_o,
  input  logic [DATA_SZ_P-1:0]          wb_dat_i,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH_P):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH_P);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_P);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH_P);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_P - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       count_reg;
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [TMO_W-1:0]       tmo_reg, tmo_next;
  logic                   cyc_reg, cyc_next;
  logic                   we_reg, we_next;
  logic [ADDR_SZ_P-1:0]   adr_reg, adr_next;
  logic [DATA_SZ_P-1:0]   dat_reg, dat_next;
  logic                   rsp_valid_reg, rsp_valid_next;
  logic [DATA_SZ_P-1:0]   rsp_data_reg, rsp_data_next;
  logic                   rsp_err_reg, rsp_err_next;
  logic                   push, pop, done;

  logic                   mem_cmd  [FIFO_DEPTH_P];
  logic [ADDR_SZ_P-1:0]   mem_addr [FIFO_DEPTH_P];
  logic [DATA_SZ_P-1:0]   mem_data [FIFO_DEPTH_P];

  // Ready comes from the registered count only, so a same-cycle pop never frees a full queue.
  assign req_ready  = (count_reg != CNT_FULL);
  assign push       = req_valid && req_ready;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);
  assign busy       = (count_reg != '0) || (state_reg != IDLE);
  assign fifo_count = count_reg;

  assign wb_cyc_o  = cyc_reg;
  assign wb_stb_o  = cyc_reg;
  assign wb_we_o   = we_reg;
  assign wb_adr_o  = adr_reg;
  assign wb_dat_o  = dat_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr_reg]  <= req_cmd;
      mem_addr[wr_ptr_reg] <= req_addr;
      mem_data[wr_ptr_reg] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      tmo_reg       <= '0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmo_reg       <= tmo_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tmo_next       = tmo_reg;
    cyc_next       = cyc_reg;
    we_next        = we_reg;
    adr_next       = adr_reg;
    dat_next       = dat_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    done           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          state_next = BUS;
          cyc_next   = 1'b1;
          we_next    = mem_cmd[rd_ptr_reg];
          adr_next   = mem_addr[rd_ptr_reg];
          dat_next   = mem_data[rd_ptr_reg];
          tmo_next   = '0;
        end
      end
      BUS: begin
        tmo_next = tmo_reg + TMO_W'(1);
        // Error outranks a simultaneous ack; timeout only when the slave stays silent.
        if (wb_err_i) begin
          done          = 1'b1;
          rsp_err_next  = 1'b1;
          rsp_data_next = '0;
        end else if (wb_ack_i) begin
          done          = 1'b1;
          rsp_err_next  = 1'b0;
          rsp_data_next = we_reg ? '0 : wb_dat_i;
        end else if (tmo_reg == TMO_LAST) begin
          done          = 1'b1;
          rsp_err_next  = 1'b1;
          rsp_data_next = '0;
        end
        if (done) begin
          state_next     = RESP;
          cyc_next       = 1'b0;
          we_next        = 1'b0;
          rsp_valid_next = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_master_queue.sv
// Bench for wb_master_queue: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a timestamp-based transaction model.
module tb_wb_master_queue;
  localparam int D = 32;
  localparam int A = 10;
  localparam int F = 4;
  localparam int T = 16;
  localparam logic [1:0] K_ACK = 2'd0, K_ERR = 2'd1, K_BOTH = 2'd2, K_NONE = 2'd3;

  typedef struct packed { logic cmd; logic [A-1:0] addr; logic [D-1:0] data; } cmd_t;
  typedef struct packed { logic err; logic [D-1:0] data; } rsp_t;
  typedef struct packed { logic [7:0] wt; logic [1:0] kind; logic [D-1:0] rdata; } plan_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_cmd = 1'b0;
  logic [A-1:0] req_addr = '0;
  logic [D-1:0] req_data = '0;
  logic [D-1:0] wb_dat_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic req_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o, busy;
  logic [D-1:0] rsp_data, wb_dat_o;
  logic [A-1:0] wb_adr_o;
  logic [$clog2(F):0] fifo_count;

  int errors = 0, checks = 0;
  bit cmp_en = 0;

  wb_master_queue #(.DATA_SZ_P(D), .ADDR_SZ_P(A), .FIFO_DEPTH_P(F), .TIMEOUT_P(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: queued commands, plus the edge numbers at which the bus
  // command started, the response pulse is due, and the next command may start.
  cmd_t mq[$];
  cmd_t cur = '0;
  bit m_bus = 0, m_push, m_fin;
  int cyc_n = 0, m_start = 0, m_rsp_cycle = -10, m_next_start = 0, m_last_push = 0;
  int m_acc_total = 0;
  logic [D-1:0] m_rdata = '0;
  logic m_rerr = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_bus = 0; m_rsp_cycle = -10; m_next_start = 0;
      m_rdata = '0; m_rerr = 1'b0; cyc_n = 0;
    end else begin
      cyc_n  = cyc_n + 1;
      m_fin  = 0;
      m_push = req_valid && (mq.size() != F);
      if (m_bus) begin
        if (wb_err_i) begin
          m_fin = 1; m_rerr = 1'b1; m_rdata = '0;
        end else if (wb_ack_i) begin
          m_fin = 1; m_rerr = 1'b0; m_rdata = cur.cmd ? '0 : wb_dat_i;
        end else if ((cyc_n - 1) - m_start == T - 1) begin
          m_fin = 1; m_rerr = 1'b1; m_rdata = '0;
        end
        if (m_fin) begin
          m_bus = 0; m_rsp_cycle = cyc_n; m_next_start = cyc_n + 2;
        end
      end else if (cyc_n >= m_next_start && mq.size() != 0) begin
        cur = mq.pop_front();
        m_bus = 1; m_start = cyc_n;
      end
      if (m_push) begin
        mq.push_back(cmd_t'{req_cmd, req_addr, req_data});
        m_acc_total++;
        m_last_push = cyc_n;
      end
    end
  end

  // Slave, monitor and per-cycle compare, all away from the active edge.
  plan_t plan_q[$];
  plan_t s_plan = '0;
  bit s_active = 0, s_hold = 0, spur_en = 0;
  int s_cnt = 0, s_r = 0, cur_len = 0, rise_cycle = 0, rsp_count = 0;
  rsp_t rsp_q[$];
  cmd_t bus_q[$];
  int len_q[$];
  logic exp_rv;

  always @(negedge clk) begin
    if (!reset) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; s_active = 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (!s_active) begin
        s_active = 1; s_cnt = 0;
        if (plan_q.size() != 0) s_plan = plan_q.pop_front();
        else begin
          s_r = $urandom_range(0, 19);
          s_plan.wt    = 8'($urandom_range(0, 4));
          s_plan.kind  = (s_r == 0) ? K_NONE : (s_r == 1) ? K_ERR : (s_r == 2) ? K_BOTH : K_ACK;
          s_plan.rdata = $urandom;
        end
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
      if (!s_hold) begin
        if (s_cnt == int'(s_plan.wt) && s_plan.kind != K_NONE) begin
          wb_ack_i = (s_plan.kind == K_ACK) || (s_plan.kind == K_BOTH);
          wb_err_i = (s_plan.kind == K_ERR) || (s_plan.kind == K_BOTH);
          wb_dat_i = s_plan.rdata;
        end
        s_cnt++;
      end
    end else begin
      s_active = 0;
      wb_ack_i = spur_en && ($urandom_range(0, 3) == 0);
      wb_err_i = spur_en && ($urandom_range(0, 7) == 0);
      wb_dat_i = $urandom;
    end

    if (!reset) cur_len = 0;
    else if (wb_cyc_o === 1'b1) begin
      if (cur_len == 0) begin
        bus_q.push_back(cmd_t'{wb_we_o, wb_adr_o, wb_dat_o});
        rise_cycle = cyc_n;
      end
      cur_len++;
    end else if (cur_len != 0) begin
      len_q.push_back(cur_len);
      cur_len = 0;
    end
    if (rsp_valid === 1'b1) begin
      rsp_q.push_back(rsp_t'{rsp_err, rsp_data});
      rsp_count++;
      $display("rsp %0d: data=0x%08h err=%0b t=%0t", rsp_count, rsp_data, rsp_err, $time);
    end

    if (cmp_en) begin
      exp_rv = (m_rsp_cycle == cyc_n);
      chk("cyc", wb_cyc_o, m_bus);
      chk("stb", wb_stb_o, m_bus);
      chk("we", wb_we_o, m_bus && cur.cmd);
      if (m_bus) begin
        chk("adr", wb_adr_o, cur.addr);
        chk("dat_o", wb_dat_o, cur.data);
      end
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_data", rsp_data, m_rdata);
      chk("rsp_err", rsp_err, m_rerr);
      chk("fifo_count", fifo_count, mq.size());
      chk("req_ready", req_ready, mq.size() != F);
      chk("busy", busy, (mq.size() != 0) || m_bus || exp_rv);
    end
  end

  function automatic rsp_t get_rsp(input int i);
    if (i < rsp_q.size()) return rsp_q[i];
    return '1;
  endfunction
  function automatic cmd_t get_bus(input int i);
    if (i < bus_q.size()) return bus_q[i];
    return '1;
  endfunction
  function automatic int get_len(input int i);
    if (i < len_q.size()) return len_q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    rsp_q.delete(); bus_q.delete(); len_q.delete();
  endtask

  task automatic push_cmd(input logic c, input logic [A-1:0] a, input logic [D-1:0] d);
    int tries = 0;
    req_valid = 1'b1; req_cmd = c; req_addr = a; req_data = d;
    while (req_ready !== 1'b1 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    chk("push_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t r;
    cmd_t b;
    int n0, a0, p;

    #2 reset = 1'b0;
    cmp_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    // single write, slave acks one cycle after stb
    clear_logs();
    plan_q.push_back(plan_t'{8'd1, K_ACK, 32'h0});
    push_cmd(1'b1, 10'h00A, 32'hDEADBEEF);
    wait_idle(100);
    chk("wr_n_rsp", rsp_q.size(), 1);
    r = get_rsp(0);
    chk("wr_rsp_err", r.err, 0);
    chk("wr_rsp_data", r.data, 0);
    b = get_bus(0);
    chk("wr_bus_we", b.cmd, 1);
    chk("wr_bus_adr", b.addr, 10'h00A);
    chk("wr_bus_dat", b.data, 32'hDEADBEEF);
    chk("wr_issue_latency", rise_cycle - m_last_push, 1);
    chk("wr_cyc_len", get_len(0), 2);

    // single read, three wait cycles
    clear_logs();
    plan_q.push_back(plan_t'{8'd3, K_ACK, 32'h12345678});
    push_cmd(1'b0, 10'h3FF, 32'h0);
    wait_idle(100);
    r = get_rsp(0);
    chk("rd_rsp_data", r.data, 32'h12345678);
    chk("rd_rsp_err", r.err, 0);
    chk("rd_cyc_len", get_len(0), 4);
    b = get_bus(0);
    chk("rd_bus_adr", b.addr, 10'h3FF);

    // fill and back-pressure with the slave stalled
    clear_logs();
    s_hold = 1;
    for (int i = 0; i < 6; i++) plan_q.push_back(plan_t'{8'($urandom_range(0, 2)), K_ACK, $urandom});
    for (int i = 0; i < 5; i++) push_cmd(1'(i & 1), A'(16 * i + 1), D'(i * 3 + 7));
    chk("fill_count", fifo_count, 4);
    chk("fill_ready", req_ready, 0);
    chk("fill_cyc", wb_cyc_o, 1);
    req_valid = 1'b1; req_cmd = 1'b1; req_addr = A'(16 * 5 + 1); req_data = 32'h55;
    @(negedge clk);
    chk("full_ready", req_ready, 0);
    chk("full_count", fifo_count, 4);
    s_hold = 0;
    push_cmd(1'b1, A'(16 * 5 + 1), 32'h55);
    wait_idle(500);
    chk("fill_n_rsp", rsp_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      b = get_bus(i);
      chk("fill_order_adr", b.addr, A'(16 * i + 1));
      r = get_rsp(i);
      chk("fill_rsp_err", r.err, 0);
    end

    // timeout, then a normal command behind it
    clear_logs();
    plan_q.push_back(plan_t'{8'd0, K_NONE, 32'h0});
    plan_q.push_back(plan_t'{8'd2, K_ACK, 32'hA5A50F0F});
    push_cmd(1'b1, 10'h055, 32'h11112222);
    push_cmd(1'b0, 10'h066, 32'h0);
    wait_idle(200);
    chk("tmo_stb_len", get_len(0), 16);
    r = get_rsp(0);
    chk("tmo_rsp_err", r.err, 1);
    chk("tmo_rsp_data", r.data, 0);
    chk("tmo_next_len", get_len(1), 3);
    r = get_rsp(1);
    chk("tmo_next_err", r.err, 0);
    chk("tmo_next_data", r.data, 32'hA5A50F0F);

    // error wins over simultaneous ack
    clear_logs();
    plan_q.push_back(plan_t'{8'd1, K_BOTH, 32'hFFFF0000});
    push_cmd(1'b0, 10'h123, 32'h0);
    wait_idle(100);
    r = get_rsp(0);
    chk("errpri_err", r.err, 1);
    chk("errpri_data", r.data, 0);

    // asynchronous reset during a bus cycle with two entries queued
    clear_logs();
    plan_q.push_back(plan_t'{8'd0, K_NONE, 32'h0});
    push_cmd(1'b1, 10'h010, 32'h1);
    push_cmd(1'b0, 10'h020, 32'h2);
    push_cmd(1'b1, 10'h030, 32'h3);
    chk("prerst_count", fifo_count, 2);
    chk("prerst_cyc", wb_cyc_o, 1);
    n0 = rsp_count;
    #2 reset = 1'b0;
    #1;
    chk("arst_cyc", wb_cyc_o, 0);
    chk("arst_stb", wb_stb_o, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    plan_q.delete();
    repeat (3) @(negedge clk);
    chk("arst_no_rsp", rsp_count, n0);
    clear_logs();
    plan_q.push_back(plan_t'{8'd1, K_ACK, 32'hCAFE0001});
    push_cmd(1'b0, 10'h200, 32'h0);
    wait_idle(100);
    r = get_rsp(0);
    chk("post_rst_data", r.data, 32'hCAFE0001);
    chk("post_rst_err", r.err, 0);

    // randomized traffic with random slave latency, errors, timeouts and stray acks
    spur_en = 1;
    n0 = rsp_count;
    a0 = m_acc_total;
    for (int blk = 0; blk < 10; blk++) begin
      p = $urandom_range(1, 9);
      for (int c = 0; c < 200; c++) begin
        req_valid = ($urandom_range(0, 9) < p);
        req_cmd   = 1'($urandom);
        req_addr  = A'($urandom);
        req_data  = $urandom;
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    wait_idle(500);
    chk("rand_rsp_total", rsp_count - n0, m_acc_total - a0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
